calc_key_fsm: RTL
=================

// Module: calc_key_fsm
// PURPOSE
//  Operand/operator entry FSM for the simple calculator; sits directly downstream of the button
//  debouncers and consumes their single-cycle, clk-synchronous key pulses.
//  Builds two 2-digit decimal operands and an operator, computes +, - or *, and converts the
//  result to 4-digit BCD with a multi-cycle shift-add-3 (double-dabble) engine for the display.
// PARAMETERS
//  IDLE_TIMEOUT  0  cycles spent in SHOW before auto-return to ENTER_A; 0 disables the timeout
// PORTS
//  clk       in   1   system clock (12 MHz)
//  rst_n     in   1   asynchronous active-low reset
//  key_inc   in   1   debounced pulse: increment current digit / cycle operator
//  key_next  in   1   debounced pulse: advance to next digit / field
//  key_eq    in   1   debounced pulse: start calculation
//  key_clr   in   1   debounced pulse: abort and clear
//  disp_bcd  out  16  four BCD digits, [15:12] = thousands
//  neg       out  1   result sign for subtraction (1 = negative)
//  op        out  2   operator code: 00 = +, 01 = -, 10 = *
//  state     out  3   ENTER_A=0, ENTER_OP=1, ENTER_B=2, CALC=3, SHOW=4
//  dig_sel   out  1   active digit in ENTER_A/B (0 = tens, 1 = units); used by display blink
//  busy      out  1   high while in CALC
//  done      out  1   one-cycle pulse on the first cycle in SHOW
// BEHAVIOUR
//  - Reset: state = ENTER_A; A, B, op, dig_sel, neg = 0; disp_bcd = 16'h0000; busy = 0; done = 0.
//  - Same-cycle key priority: key_clr > key_eq > key_next > key_inc. Only one key acts per cycle.
//  - key_clr in any state, including CALC: next cycle ENTER_A with all registers at reset values.
//  - ENTER_A / ENTER_B: key_inc adds 1 to the active digit, wrapping 9 -> 0.
//    key_next with dig_sel = 0: set dig_sel = 1.
//    key_next with dig_sel = 1: set dig_sel = 0 and advance (A -> ENTER_OP, B -> no effect).
//  - ENTER_OP: key_inc cycles op 00 -> 01 -> 10 -> 00; key_next -> ENTER_B.
//  - key_eq is honoured only in ENTER_B, at any digit; it is ignored in every other state.
//  - Display in entry states: ENTER_A and ENTER_OP show {0, 0, A_tens, A_units}; ENTER_B shows
//    {0, 0, B_tens, B_units}. disp_bcd holds its last value throughout CALC.
//  - CALC timing (N = edge that enters CALC):
//    cycle 0: Av = 10*A_tens + A_units and Bv likewise (7-bit); 14-bit result R computed:
//      + : R = Av + Bv
//      - : R = |Av - Bv|, neg = (Av < Bv)
//      * : R = Av * Bv, max 9801
//    cycles 1..14: one double-dabble iteration each. The BCD register is 16 bits with no overflow,
//      since R <= 9999.
//    edge N+15: enter SHOW, disp_bcd = BCD(R), done = 1 for that cycle. busy is high for exactly
//      15 cycles.
//  - neg is cleared on entry to CALC for + and *; neg = 1 never occurs with R = 0.
//  - SHOW: key_next or key_eq clears A, B, op and neg, sets disp_bcd = 0, goes to ENTER_A.
//    key_inc is ignored.
//  - SHOW timeout: if IDLE_TIMEOUT != 0, a counter cleared on SHOW entry returns the FSM to
//    ENTER_A (same clear as key_next) when it reaches IDLE_TIMEOUT - 1. The counter is
//    $clog2(IDLE_TIMEOUT + 1) bits wide.
//  - Keys in CALC other than key_clr are ignored. Unused state encodings go to ENTER_A.
//  - Reset asserted mid-CALC clears immediately and asynchronously; no done pulse follows.
// TESTING
//  1. Reset, no keys -> state = 0, disp_bcd = 16'h0000, busy = 0, done = 0.
//  2. Enter 12, op +, enter 34, key_eq -> busy high for 15 cycles, then disp_bcd = 16'h0046,
//     neg = 0, done pulses once.
//  3. Enter 05, op -, enter 37, key_eq -> disp_bcd = 16'h0032, neg = 1. Repeat with 37 - 05:
//     disp_bcd = 16'h0032, neg = 0.
//  4. Enter 99, op *, enter 99, key_eq -> disp_bcd = 16'h9801. Enter 00 * 57 -> 16'h0000.
//  5. Ten key_inc pulses on A tens -> digit returns to 0. key_inc and key_next in the same cycle
//     -> only dig_sel changes.
//  6. key_clr 5 cycles into CALC -> ENTER_A next cycle, busy = 0, no done pulse.
//     With IDLE_TIMEOUT = 20: SHOW exits to ENTER_A after exactly 20 cycles.

Source files
------------

// File: rtl/calc_key_if.sv
// Key-pulse inputs and display/status outputs of the calculator entry FSM.
interface calc_key_if;
  logic        key_inc;
  logic        key_next;
  logic        key_eq;
  logic        key_clr;
  logic [15:0] disp_bcd;
  logic        neg;
  logic [1:0]  op;
  logic [2:0]  state;
  logic        dig_sel;
  logic        busy;
  logic        done;

  // Key source side (debouncers or bench)
  modport master (
    output key_inc, key_next, key_eq, key_clr,
    input  disp_bcd, neg, op, state, dig_sel, busy, done
  );

  // FSM side
  modport slave (
    input  key_inc, key_next, key_eq, key_clr,
    output disp_bcd, neg, op, state, dig_sel, busy, done
  );
endinterface

// File: rtl/calc_key_fsm.sv
// Calculator operand/operator entry FSM: two 2-digit decimal operands, an operator
// (+, -, *), result computation and a 14-step double-dabble conversion to 4-digit BCD.
module calc_key_fsm #(
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  calc_key_if.slave  bus
);

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_OP = 3'd1,
    ENTER_B  = 3'd2,
    CALC     = 3'd3,
    SHOW     = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  // A zero-width counter is not legal, so keep one bit when the timeout is disabled.
  localparam int              TMO_W    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);

  state_t           state_q;
  logic [3:0]       a_t_q, a_u_q, b_t_q, b_u_q;
  logic [1:0]       op_q;
  logic             dig_sel_q;
  logic             neg_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      disp_q;
  logic [3:0]       calc_cnt_q;
  logic [29:0]      sh_q;       // {bcd[15:0], bin[13:0]}
  logic [TMO_W-1:0] tmo_q;

  function automatic logic [3:0] dig_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // One shift-add-3 iteration: correct each BCD digit >= 5, then shift left.
  function automatic logic [29:0] dabble_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd5) t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  logic [6:0]  a_val, b_val;
  logic        a_lt_b;
  logic [13:0] r_val;
  logic [29:0] sh_nxt;
  logic [3:0]  cur_t, cur_u, inc_t, inc_u;
  logic        k_eq, k_next, k_inc;
  logic        tmo_hit, go_home;

  // Operand values, result, key priority decode and the "return to ENTER_A" condition
  always_comb begin
    a_val  = 7'(a_t_q) * 7'd10 + 7'(a_u_q);
    b_val  = 7'(b_t_q) * 7'd10 + 7'(b_u_q);
    a_lt_b = (a_val < b_val);
    case (op_q)
      OP_ADD:  r_val = {7'd0, a_val} + {7'd0, b_val};
      OP_SUB:  r_val = a_lt_b ? {7'd0, 7'(b_val - a_val)} : {7'd0, 7'(a_val - b_val)};
      OP_MUL:  r_val = {7'd0, a_val} * {7'd0, b_val};
      default: r_val = 14'd0;
    endcase
    sh_nxt = dabble_step(sh_q);

    cur_t  = (state_q == ENTER_B) ? b_t_q : a_t_q;
    cur_u  = (state_q == ENTER_B) ? b_u_q : a_u_q;
    inc_t  = dig_sel_q ? cur_t : dig_inc(cur_t);
    inc_u  = dig_sel_q ? dig_inc(cur_u) : cur_u;

    k_eq   = !bus.key_clr && bus.key_eq;
    k_next = !bus.key_clr && !bus.key_eq && bus.key_next;
    k_inc  = !bus.key_clr && !bus.key_eq && !bus.key_next && bus.key_inc;

    tmo_hit = (IDLE_TIMEOUT != 0) && (tmo_q == TMO_LAST);
    go_home = bus.key_clr
           || ((state_q == SHOW) && (k_eq || k_next || tmo_hit))
           || (state_q > SHOW);
  end

  // Main FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENTER_A;
      a_t_q      <= 4'd0;
      a_u_q      <= 4'd0;
      b_t_q      <= 4'd0;
      b_u_q      <= 4'd0;
      op_q       <= OP_ADD;
      dig_sel_q  <= 1'b0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      disp_q     <= 16'h0000;
      calc_cnt_q <= 4'd0;
      sh_q       <= 30'd0;
      tmo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (go_home) begin
        state_q   <= ENTER_A;
        a_t_q     <= 4'd0;
        a_u_q     <= 4'd0;
        b_t_q     <= 4'd0;
        b_u_q     <= 4'd0;
        op_q      <= OP_ADD;
        dig_sel_q <= 1'b0;
        neg_q     <= 1'b0;
        busy_q    <= 1'b0;
        disp_q    <= 16'h0000;
      end else begin
        case (state_q)
          ENTER_A, ENTER_B: begin
            if (k_eq) begin
              if (state_q == ENTER_B) begin
                state_q    <= CALC;
                busy_q     <= 1'b1;
                calc_cnt_q <= 4'd0;
                if (op_q != OP_SUB) neg_q <= 1'b0;
              end
            end else if (k_next) begin
              dig_sel_q <= !dig_sel_q;
              if (dig_sel_q && (state_q == ENTER_A)) state_q <= ENTER_OP;
            end else if (k_inc) begin
              if (state_q == ENTER_A) begin
                a_t_q <= inc_t;
                a_u_q <= inc_u;
              end else begin
                b_t_q <= inc_t;
                b_u_q <= inc_u;
              end
              disp_q <= {8'h00, inc_t, inc_u};
            end
          end
          ENTER_OP: begin
            if (k_next) begin
              state_q <= ENTER_B;
              disp_q  <= {8'h00, b_t_q, b_u_q};
            end else if (k_inc) begin
              op_q <= (op_q == OP_MUL) ? OP_ADD : op_q + 2'd1;
            end
          end
          CALC: begin
            // Step 0 latches the binary result; steps 1..14 run the conversion.
            if (calc_cnt_q == 4'd0) begin
              sh_q       <= {16'h0000, r_val};
              neg_q      <= (op_q == OP_SUB) && a_lt_b;
              calc_cnt_q <= 4'd1;
            end else begin
              sh_q <= sh_nxt;
              if (calc_cnt_q == 4'd14) begin
                state_q <= SHOW;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                disp_q  <= sh_nxt[29:14];
                tmo_q   <= '0;
              end else begin
                calc_cnt_q <= calc_cnt_q + 4'd1;
              end
            end
          end
          SHOW: begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
          default: state_q <= ENTER_A;
        endcase
      end
    end
  end

  assign bus.disp_bcd = disp_q;
  assign bus.neg      = neg_q;
  assign bus.op       = op_q;
  assign bus.state    = state_q;
  assign bus.dig_sel  = dig_sel_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
